// File: rtl/mpc_loop_pipe_ctrl_if.sv
// Handshake bundle between the loop flow-control wrapper
// and the loop-body pipeline controller.
interface mpc_loop_pipe_ctrl_if #(
  parameter int TRIP_W = 16,
  parameter int DEPTH  = 4
);
  logic              ap_start_int;
  logic              ap_loop_init;
  logic [TRIP_W-1:0] trip_count;
  logic              ap_block;
  logic              ap_ready_int;
  logic              ap_done_int;
  logic              ap_loop_exit_ready;
  logic              ap_loop_exit_done;
  logic              issue;
  logic [TRIP_W-1:0] iter_idx;
  logic              iter_first;
  logic [DEPTH-1:0]  stage_valid;
  logic [31:0]       stall_cycles;

  modport master (
    output ap_start_int,
    output ap_loop_init,
    output trip_count,
    output ap_block,
    input  ap_ready_int,
    input  ap_done_int,
    input  ap_loop_exit_ready,
    input  ap_loop_exit_done,
    input  issue,
    input  iter_idx,
    input  iter_first,
    input  stage_valid,
    input  stall_cycles
  );

  modport slave (
    input  ap_start_int,
    input  ap_loop_init,
    input  trip_count,
    input  ap_block,
    output ap_ready_int,
    output ap_done_int,
    output ap_loop_exit_ready,
    output ap_loop_exit_done,
    output issue,
    output iter_idx,
    output iter_first,
    output stage_valid,
    output stall_cycles
  );
endinterface

// File: rtl/mpc_loop_pipe_ctrl.sv
// Loop-body pipeline controller: N iterations at fixed II through DEPTH stages.
// Optional stall statistics enabled by MPC_LOOP_PIPE_STATS_EN.
module mpc_loop_pipe_ctrl #(
  parameter int TRIP_W = 16,
  parameter int II     = 1,
  parameter int DEPTH  = 4
) (
  input logic ap_clk,
  input logic ap_rst_n,
  mpc_loop_pipe_ctrl_if.slave bus
);
  localparam int IIW = (II > 1) ? $clog2(II) : 1;
  localparam int DW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IIW-1:0]    II_LOAD = IIW'(II - 1);
  localparam logic [IIW-1:0]    II_ONE  = IIW'(1);
  localparam logic [DW-1:0]     D_LOAD  = DW'(DEPTH - 1);
  localparam logic [DW-1:0]     D_ONE   = DW'(1);
  localparam logic [TRIP_W-1:0] T_ONE   = TRIP_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    RUN,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              start;
  logic              block;
  logic [TRIP_W-1:0] trip;

  logic [TRIP_W-1:0] n_q;
  logic [TRIP_W-1:0] iter_q;
  logic [IIW-1:0]    ii_q;
  logic [DW-1:0]     drain_q;
  logic [DEPTH-1:0]  sv_q;
  logic [DEPTH-1:0]  sv_d;

  logic accept;
  logic issue;
  logic ready;
  logic done;
  logic exit_ready;
  logic last;
  logic ii_zero;
  logic drain_zero;
  logic shift_en;
  logic in_run;
  logic in_drain;

  assign start = bus.ap_start_int;
  assign block = bus.ap_block;
  assign trip  = bus.trip_count;

  assign in_run     = (state_q == RUN);
  assign in_drain   = (state_q == DRAIN);
  assign ii_zero    = (ii_q == '0);
  assign drain_zero = (drain_q == '0);
  assign last       = (iter_q == n_q - T_ONE);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue      = 1'b0;
    ready      = 1'b0;
    done       = 1'b0;
    exit_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (trip == '0) ? ZERO : RUN;
        end
      end
      ZERO: begin
        ready      = 1'b1;
        exit_ready = 1'b1;
        done       = 1'b1;
        state_d    = IDLE;
      end
      RUN: begin
        issue = ii_zero & ~block;
        ready = issue;
        if (issue & last) begin
          exit_ready = 1'b1;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (~block & drain_zero) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      n_q    <= '0;
      iter_q <= '0;
    end else if (accept) begin
      n_q    <= trip;
      iter_q <= '0;
    end else if (issue) begin
      iter_q <= iter_q + T_ONE;
    end
  end

  // II spacing counter; frozen while stalled
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ii_q <= '0;
    end else begin
      unique case (1'b1)
        accept: ii_q <= '0;
        issue:  ii_q <= II_LOAD;
        (in_run & ~block & ~ii_zero):
          ii_q <= ii_q - II_ONE;
        default: ii_q <= ii_q;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      drain_q <= '0;
    end else begin
      unique case (1'b1)
        (issue & last): drain_q <= D_LOAD;
        (in_drain & ~block & ~drain_zero):
          drain_q <= drain_q - D_ONE;
        default: drain_q <= drain_q;
      endcase
    end
  end

  generate
    if (DEPTH == 1) begin : g_sv1
      assign sv_d = issue;
    end else begin : g_svn
      assign sv_d = {sv_q[DEPTH-2:0], issue};
    end
  endgenerate

  // ZERO ignores the stall, so the valid pipe keeps moving there
  assign shift_en = ~block | (state_q == ZERO);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sv_q <= '0;
    end else if (shift_en) begin
      sv_q <= sv_d;
    end
  end

`ifdef MPC_LOOP_PIPE_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((in_run | in_drain) & block &
                 (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.issue              = issue;
  assign bus.ap_ready_int       = ready;
  assign bus.ap_done_int        = done;
  assign bus.ap_loop_exit_ready = exit_ready;
  assign bus.ap_loop_exit_done  = done;
  assign bus.iter_idx           = iter_q;
  assign bus.iter_first         = issue & bus.ap_loop_init;
  assign bus.stage_valid        = sv_q;
endmodule

// File: tb/tb_mpc_loop_pipe_ctrl.sv
// Bench for mpc_loop_pipe_ctrl: two configurations against an
// issue-schedule model plus literal timeline checks.
module tb_mpc_loop_pipe_ctrl;
  localparam int TW   = 16;
  localparam int II_A = 1;
  localparam int D_A  = 4;
  localparam int II_B = 3;
  localparam int D_B  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          init  = 1'b0;
  logic          block = 1'b0;
  logic [TW-1:0] trip  = '0;

  int n_checks = 0;
  int n_err    = 0;

  mpc_loop_pipe_ctrl_if #(.TRIP_W(TW), .DEPTH(D_A)) ifa ();
  mpc_loop_pipe_ctrl_if #(.TRIP_W(TW), .DEPTH(D_B)) ifb ();

  assign ifa.ap_start_int = start;
  assign ifa.ap_loop_init = init;
  assign ifa.trip_count   = trip;
  assign ifa.ap_block     = block;
  assign ifb.ap_start_int = start;
  assign ifb.ap_loop_init = init;
  assign ifb.trip_count   = trip;
  assign ifb.ap_block     = block;

  mpc_loop_pipe_ctrl #(.TRIP_W(TW), .II(II_A), .DEPTH(D_A)) dut_a (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .bus     (ifa)
  );

  mpc_loop_pipe_ctrl #(.TRIP_W(TW), .II(II_B), .DEPTH(D_B)) dut_b (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .bus     (ifb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %0h expected %0h",
               nm, inst, $time, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 zero-trip, 2 busy. Busy timing is a
  // schedule over unstalled cycles u: issue k at u==k*II, done
  // at u==(N-1)*II+DEPTH.
  int     m_phase[2];
  int     m_n[2];
  int     m_u[2];
  int     m_k[2];
  longint m_stall[2];
  bit     hqa[$];
  bit     hqb[$];

  function automatic bit hist_get(input int i, input int j);
    int k;
    if (i == 0) begin
      k = hqa.size() - 1 - j;
      return (k >= 0) ? hqa[k] : 1'b0;
    end
    k = hqb.size() - 1 - j;
    return (k >= 0) ? hqb[k] : 1'b0;
  endfunction

  task automatic model_step(input int i);
    logic [5:0]  a_ctrl;
    logic [3:0]  a_sv;
    logic [31:0] a_st;
    logic [15:0] a_idx;
    logic [3:0]  e_sv;
    logic [31:0] e_st;
    int ii, dd;
    bit e_rdy, e_don, e_xr, e_iss, shift;
    if (i == 0) begin
      a_ctrl = {ifa.ap_ready_int, ifa.ap_done_int,
                ifa.ap_loop_exit_ready, ifa.ap_loop_exit_done,
                ifa.issue, ifa.iter_first};
      a_sv  = ifa.stage_valid;
      a_st  = ifa.stall_cycles;
      a_idx = ifa.iter_idx;
      ii = II_A;
      dd = D_A;
    end else begin
      a_ctrl = {ifb.ap_ready_int, ifb.ap_done_int,
                ifb.ap_loop_exit_ready, ifb.ap_loop_exit_done,
                ifb.issue, ifb.iter_first};
      a_sv  = {2'b00, ifb.stage_valid};
      a_st  = ifb.stall_cycles;
      a_idx = ifb.iter_idx;
      ii = II_B;
      dd = D_B;
    end
    if (!rst_n) begin
      chk("rst_ctrl", i, 32'(a_ctrl), 32'd0);
      chk("rst_sv", i, 32'(a_sv), 32'd0);
      chk("rst_stall", i, a_st, 32'd0);
      chk("rst_idx", i, 32'(a_idx), 32'd0);
      m_phase[i] = 0;
      m_stall[i] = 0;
      if (i == 0) hqa.delete();
      else hqb.delete();
      return;
    end
`ifdef MPC_LOOP_PIPE_STATS_EN
    e_st = 32'(m_stall[i]);
`else
    e_st = 32'd0;
`endif
    e_sv = '0;
    for (int j = 0; j < dd; j++) e_sv[j] = hist_get(i, j);
    e_rdy = 0;
    e_don = 0;
    e_xr  = 0;
    e_iss = 0;
    shift = !block;
    case (m_phase[i])
      0: begin
        if (start) begin
          m_stall[i] = 0;
          if (trip == '0) begin
            m_phase[i] = 1;
          end else begin
            m_phase[i] = 2;
            m_n[i] = int'(trip);
            m_u[i] = 0;
            m_k[i] = 0;
          end
        end
      end
      1: begin
        e_rdy = 1;
        e_don = 1;
        e_xr  = 1;
        shift = 1;
        m_phase[i] = 0;
      end
      default: begin
        if (block) begin
          if (m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
        end else begin
          if (m_k[i] < m_n[i] && m_u[i] == m_k[i] * ii) begin
            e_iss = 1;
            e_rdy = 1;
            e_xr  = (m_k[i] == m_n[i] - 1);
            chk("iter_idx", i, 32'(a_idx), 32'(m_k[i]));
          end
          if (m_u[i] == (m_n[i] - 1) * ii + dd) begin
            e_don = 1;
            m_phase[i] = 0;
          end
          m_u[i]++;
          if (e_iss) m_k[i]++;
        end
      end
    endcase
    chk("ctrl", i, 32'(a_ctrl),
        32'({e_rdy, e_don, e_xr, e_don, e_iss, e_iss & init}));
    chk("stage_valid", i, 32'(a_sv), 32'(e_sv));
    chk("stall_cycles", i, a_st, e_st);
    if (shift) begin
      if (i == 0) hqa.push_back(e_iss);
      else hqb.push_back(e_iss);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Per-run timelines (bit r = relative cycle r) for literal checks
  logic [31:0] iss_m[2];
  logic [31:0] don_m[2];
  logic [31:0] xr_m[2];
  logic [31:0] xd_m[2];
  logic [31:0] rdy_m[2];
  logic [31:0] fst_m[2];
  logic [3:0]  sv_at[32];
  logic [5:0]  ctrl_at[32];
  logic [15:0] idx_at[32];
  logic [31:0] st_end;

  task automatic sample(input int r);
    iss_m[0][r] = ifa.issue;
    don_m[0][r] = ifa.ap_done_int;
    xr_m[0][r]  = ifa.ap_loop_exit_ready;
    xd_m[0][r]  = ifa.ap_loop_exit_done;
    rdy_m[0][r] = ifa.ap_ready_int;
    fst_m[0][r] = ifa.iter_first;
    iss_m[1][r] = ifb.issue;
    don_m[1][r] = ifb.ap_done_int;
    xr_m[1][r]  = ifb.ap_loop_exit_ready;
    xd_m[1][r]  = ifb.ap_loop_exit_done;
    rdy_m[1][r] = ifb.ap_ready_int;
    fst_m[1][r] = ifb.iter_first;
    sv_at[r]   = ifa.stage_valid;
    idx_at[r]  = ifa.iter_idx;
    ctrl_at[r] = {ifa.ap_ready_int, ifa.ap_done_int,
                  ifa.ap_loop_exit_ready, ifa.ap_loop_exit_done,
                  ifa.issue, ifa.iter_first};
  endtask

  task automatic run_dir(input int n, input int blo, input int bhi,
                         input int ncyc, input int rst_at);
    for (int i = 0; i < 2; i++) begin
      iss_m[i] = '0;
      don_m[i] = '0;
      xr_m[i]  = '0;
      xd_m[i]  = '0;
      rdy_m[i] = '0;
      fst_m[i] = '0;
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    trip  = TW'(n);
    init  = 1'b1;
    block = 1'b0;
    for (int r = 0; r < ncyc; r++) begin
      @(negedge clk);
      sample(r);
      @(posedge clk);
      #1;
      start = 1'b0;
      trip  = TW'($urandom);
      init  = (r + 1 < 2);
      block = (r + 1 >= blo) && (r + 1 <= bhi);
      if (r + 1 == rst_at) rst_n = 1'b0;
      if (r + 1 == rst_at + 2) rst_n = 1'b1;
    end
    st_end = ifa.stall_cycles;
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // N=3, no stalls
    run_dir(3, 99, 0, 14, -1);
    chk("s1_issue", 0, iss_m[0], 32'h0000_000E);
    chk("s1_idx", 0,
        32'({idx_at[1][3:0], idx_at[2][3:0], idx_at[3][3:0]}),
        32'h0000_0012);
    chk("s1_exit_ready", 0, xr_m[0], 32'h0000_0008);
    chk("s1_done", 0, don_m[0], 32'h0000_0080);
    chk("s1_exit_done", 0, xd_m[0], 32'h0000_0080);
    chk("s1_iter_first", 0, fst_m[0], 32'h0000_0002);
    chk("s1_issue", 1, iss_m[1], 32'h0000_0092);
    chk("s1_done", 1, don_m[1], 32'h0000_0200);

    // N=2
    run_dir(2, 99, 0, 12, -1);
    chk("s2_issue", 1, iss_m[1], 32'h0000_0012);
    chk("s2_ready", 1, rdy_m[1], 32'h0000_0012);
    chk("s2_done", 1, don_m[1], 32'h0000_0040);
    chk("s2_done", 0, don_m[0], 32'h0000_0040);

    // N=0 zero-trip
    run_dir(0, 99, 0, 6, -1);
    chk("s3_ready", 0, rdy_m[0], 32'h0000_0002);
    chk("s3_exit_ready", 0, xr_m[0], 32'h0000_0002);
    chk("s3_exit_done", 0, xd_m[0], 32'h0000_0002);
    chk("s3_done", 0, don_m[0], 32'h0000_0002);
    chk("s3_issue", 0, iss_m[0], 32'h0000_0000);
    chk("s3_done", 1, don_m[1], 32'h0000_0002);

    // N=4 with stall at cycles 2-3
    run_dir(4, 2, 3, 20, -1);
    chk("s4_issue", 0, iss_m[0], 32'h0000_0072);
    chk("s4_done", 0, don_m[0], 32'h0000_0400);
    chk("s4_sv_c2", 0, 32'(sv_at[2]), 32'h1);
    chk("s4_sv_c3", 0, 32'(sv_at[3]), 32'h1);
    chk("s4_sv_c5", 0, 32'(sv_at[5]), 32'h3);
`ifdef MPC_LOOP_PIPE_STATS_EN
    chk("s4_stall", 0, st_end, 32'd2);
`else
    chk("s4_stall", 0, st_end, 32'd0);
`endif

    // reset while iteration 2 would issue
    run_dir(10, 99, 0, 10, 3);
    chk("s5_issue", 0, iss_m[0], 32'h0000_0006);
    chk("s5_rst_ctrl", 0, 32'(ctrl_at[3]), 32'd0);
    chk("s5_rst_sv", 0, 32'(sv_at[3]), 32'd0);
    chk("s5_rst_idx", 0, 32'(idx_at[3]), 32'd0);
    chk("s5_no_done", 0, don_m[0], 32'd0);
    chk("s5_no_done", 1, don_m[1], 32'd0);
    run_dir(1, 99, 0, 10, -1);
    chk("s6_issue", 0, iss_m[0], 32'h0000_0002);
    chk("s6_done", 0, don_m[0], 32'h0000_0020);
    chk("s6_done", 1, don_m[1], 32'h0000_0008);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      start = ($urandom % 4 == 0);
      trip  = ($urandom % 5 == 0) ? '0 : TW'($urandom_range(1, 6));
      init  = $urandom % 2;
      block = ($urandom % 5 == 0);
      rst_n = ($urandom % 300 != 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    block = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end
endmodule
